// File: rtl/recovery_arbiter.sv
// recovery_arbiter: picks the oldest pending recovery event (exception,
// memory-order violation or branch mispredict) and sequences
// flush -> restore -> redirect, letting older events preempt younger ones.
// Optional counters: define RECOVERY_ARBITER_STATS_EN to add stat_* outputs.
module recovery_arbiter #(
  parameter int NUM_BR_PORTS   = 2,
  parameter int ROB_IDX_W      = 7,
  parameter int CKPT_W         = 3,
  parameter int RESTORE_CYCLES = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ROB_IDX_W-1:0]             rob_head_idx,
  input  logic                             exc_valid,
  input  logic [31:0]                      exc_pc,
  input  logic [ROB_IDX_W-1:0]             exc_rob_idx,
  input  logic                             memv_valid,
  input  logic [31:0]                      memv_pc,
  input  logic [ROB_IDX_W-1:0]             memv_rob_idx,
  input  logic [NUM_BR_PORTS-1:0]          br_valid,
  input  logic [32*NUM_BR_PORTS-1:0]       br_pc,
  input  logic [ROB_IDX_W*NUM_BR_PORTS-1:0] br_rob_idx,
  input  logic [CKPT_W*NUM_BR_PORTS-1:0]   br_ckpt,
  output logic                             flush,
  output logic [ROB_IDX_W-1:0]             flush_rob_idx,
  output logic [1:0]                       flush_kind,
  output logic                             rat_restore,
  output logic [CKPT_W-1:0]                rat_restore_ckpt,
  output logic                             rat_arch_recover,
  output logic                             redirect_valid,
  output logic [31:0]                      redirect_pc,
  output logic                             busy,
  output logic                             preempt_pulse
`ifdef RECOVERY_ARBITER_STATS_EN
  ,
  output logic [15:0]                      stat_branch,
  output logic [15:0]                      stat_memory,
  output logic [15:0]                      stat_exception,
  output logic [15:0]                      stat_preempt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RESTORE, S_REDIRECT} state_t;

  localparam logic [1:0] K_BR  = 2'b01;
  localparam logic [1:0] K_MEM = 2'b10;
  localparam logic [1:0] K_EXC = 2'b11;
  localparam int CNT_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTORE_CYCLES - 1);

  logic [NUM_BR_PORTS-1:0][31:0]           br_pc_a;
  logic [NUM_BR_PORTS-1:0][ROB_IDX_W-1:0]  br_idx_a;
  logic [NUM_BR_PORTS-1:0][CKPT_W-1:0]     br_ckpt_a;
  logic [NUM_BR_PORTS-1:0][ROB_IDX_W-1:0]  br_age;

  assign br_pc_a   = br_pc;
  assign br_idx_a  = br_rob_idx;
  assign br_ckpt_a = br_ckpt;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           pc_q, pc_d;
  logic [ROB_IDX_W-1:0]  idx_q, idx_d;
  logic [CKPT_W-1:0]     ckpt_q, ckpt_d;
  logic [1:0]            kind_q, kind_d;

  logic                  cand_valid, cand_exc;
  logic [1:0]            cand_kind;
  logic [31:0]           cand_pc;
  logic [ROB_IDX_W-1:0]  cand_idx, cand_age, cur_age, memv_age;
  logic [CKPT_W-1:0]     cand_ckpt;
  logic                  preempt, accept;

  // Age of every branch port relative to the current ROB head.
  always_comb begin
    for (int i = 0; i < NUM_BR_PORTS; i++) br_age[i] = br_idx_a[i] - rob_head_idx;
  end

  assign memv_age = memv_rob_idx - rob_head_idx;
  assign cur_age  = idx_q - rob_head_idx;

  // Oldest-event selection; strict '<' keeps memv ahead of branches and low ports ahead on ties.
  always_comb begin
    cand_valid = 1'b0;
    cand_exc   = 1'b0;
    cand_kind  = 2'b00;
    cand_pc    = '0;
    cand_idx   = '0;
    cand_ckpt  = '0;
    cand_age   = '0;
    if (exc_valid) begin
      cand_valid = 1'b1;
      cand_exc   = 1'b1;
      cand_kind  = K_EXC;
      cand_pc    = exc_pc;
      cand_idx   = exc_rob_idx;
      cand_age   = exc_rob_idx - rob_head_idx;
    end else begin
      if (memv_valid) begin
        cand_valid = 1'b1;
        cand_kind  = K_MEM;
        cand_pc    = memv_pc;
        cand_idx   = memv_rob_idx;
        cand_age   = memv_age;
      end
      for (int i = 0; i < NUM_BR_PORTS; i++) begin
        if (br_valid[i] && (!cand_valid || br_age[i] < cand_age)) begin
          cand_valid = 1'b1;
          cand_kind  = K_BR;
          cand_pc    = br_pc_a[i];
          cand_idx   = br_idx_a[i];
          cand_ckpt  = br_ckpt_a[i];
          cand_age   = br_age[i];
        end
      end
    end
  end

  // The in-flight age is recomputed against today's head, since the head moves while we sequence.
  assign preempt = ~rst && (state_q != S_IDLE) && cand_valid && (cand_exc || cand_age < cur_age);
  assign accept  = ((state_q == S_IDLE) && cand_valid) || preempt;

  // Next-state and latched-field computation; a new accepted event overrides normal progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    ckpt_d  = ckpt_q;
    kind_d  = kind_q;
    case (state_q)
      S_FLUSH: begin
        state_d = (kind_q == K_MEM) ? S_REDIRECT : S_RESTORE;
        cnt_d   = CNT_LOAD;
      end
      S_RESTORE: begin
        if (cnt_q == '0) state_d = S_REDIRECT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_REDIRECT: state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = S_FLUSH;
      cnt_d   = CNT_LOAD;
      pc_d    = cand_pc;
      idx_d   = cand_idx;
      ckpt_d  = cand_ckpt;
      kind_d  = cand_kind;
    end
  end

`ifdef RECOVERY_ARBITER_STATS_EN
  logic [15:0] stat_branch_q, stat_branch_d;
  logic [15:0] stat_memory_q, stat_memory_d;
  logic [15:0] stat_exception_q, stat_exception_d;
  logic [15:0] stat_preempt_q, stat_preempt_d;

  // Saturating event counters, bumped on every entry into FLUSH and on preemption.
  always_comb begin
    stat_branch_d    = stat_branch_q;
    stat_memory_d    = stat_memory_q;
    stat_exception_d = stat_exception_q;
    stat_preempt_d   = stat_preempt_q;
    if (accept && cand_kind == K_BR  && stat_branch_q    != 16'hFFFF) stat_branch_d    = stat_branch_q + 16'd1;
    if (accept && cand_kind == K_MEM && stat_memory_q    != 16'hFFFF) stat_memory_d    = stat_memory_q + 16'd1;
    if (accept && cand_kind == K_EXC && stat_exception_q != 16'hFFFF) stat_exception_d = stat_exception_q + 16'd1;
    if (preempt && stat_preempt_q != 16'hFFFF) stat_preempt_d = stat_preempt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branch_q    <= '0;
      stat_memory_q    <= '0;
      stat_exception_q <= '0;
      stat_preempt_q   <= '0;
    end else begin
      stat_branch_q    <= stat_branch_d;
      stat_memory_q    <= stat_memory_d;
      stat_exception_q <= stat_exception_d;
      stat_preempt_q   <= stat_preempt_d;
    end
  end

  assign stat_branch    = stat_branch_q;
  assign stat_memory    = stat_memory_q;
  assign stat_exception = stat_exception_q;
  assign stat_preempt   = stat_preempt_q;
`endif

  // Sequencer state and latched event fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      idx_q   <= '0;
      ckpt_q  <= '0;
      kind_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      ckpt_q  <= ckpt_d;
      kind_q  <= kind_d;
    end
  end

  // Outputs decode the registered state; a preempting cycle masks restore/redirect so the
  // stale event never reaches the RAT or fetch, while an in-progress flush still goes out.
  assign flush            = (state_q == S_FLUSH);
  assign flush_rob_idx    = flush ? idx_q  : '0;
  assign flush_kind       = flush ? kind_q : 2'b00;
  assign rat_restore      = (state_q == S_RESTORE) && (kind_q == K_BR) && !preempt;
  assign rat_restore_ckpt = rat_restore ? ckpt_q : '0;
  assign rat_arch_recover = (state_q == S_RESTORE) && (kind_q == K_EXC) && !preempt;
  assign redirect_valid   = (state_q == S_REDIRECT) && !preempt;
  assign redirect_pc      = redirect_valid ? pc_q : '0;
  assign busy             = (state_q != S_IDLE);
  assign preempt_pulse    = preempt;

endmodule

// File: tb/tb_recovery_arbiter.sv
// Scoreboard bench for recovery_arbiter: a timeline model schedules the
// expected flush/restore/redirect activity of each accepted event, and a
// negedge monitor pops and compares whenever the DUT shows activity.
module tb_recovery_arbiter;
  localparam int N = 2, W = 7, CW = 3, R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] rob_head_idx = '0;
  logic exc_valid = 1'b0, memv_valid = 1'b0;
  logic [31:0] exc_pc = '0, memv_pc = '0;
  logic [W-1:0] exc_rob_idx = '0, memv_rob_idx = '0;
  logic [N-1:0] br_valid = '0;
  logic [32*N-1:0] br_pc = '0;
  logic [W*N-1:0] br_rob_idx = '0;
  logic [CW*N-1:0] br_ckpt = '0;
  logic flush, rat_restore, rat_arch_recover, redirect_valid, busy, preempt_pulse;
  logic [W-1:0] flush_rob_idx;
  logic [1:0] flush_kind;
  logic [CW-1:0] rat_restore_ckpt;
  logic [31:0] redirect_pc;
`ifdef RECOVERY_ARBITER_STATS_EN
  logic [15:0] stat_branch, stat_memory, stat_exception, stat_preempt;
`endif

  recovery_arbiter #(.NUM_BR_PORTS(N), .ROB_IDX_W(W), .CKPT_W(CW), .RESTORE_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .rob_head_idx(rob_head_idx),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_rob_idx(exc_rob_idx),
    .memv_valid(memv_valid), .memv_pc(memv_pc), .memv_rob_idx(memv_rob_idx),
    .br_valid(br_valid), .br_pc(br_pc), .br_rob_idx(br_rob_idx), .br_ckpt(br_ckpt),
    .flush(flush), .flush_rob_idx(flush_rob_idx), .flush_kind(flush_kind),
    .rat_restore(rat_restore), .rat_restore_ckpt(rat_restore_ckpt),
    .rat_arch_recover(rat_arch_recover), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .preempt_pulse(preempt_pulse)
`ifdef RECOVERY_ARBITER_STATS_EN
    , .stat_branch(stat_branch), .stat_memory(stat_memory),
    .stat_exception(stat_exception), .stat_preempt(stat_preempt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic         fl;
    logic [W-1:0] idx;
    logic [1:0]   kind;
    logic         rs;
    logic [CW-1:0] ck;
    logic         ar;
    logic         rd;
    logic [31:0]  pc;
    logic         pre;
  } rec_t;

  rec_t q[$];
  rec_t slot[16];
  logic exp_busy[16];
  int checks = 0, passes = 0;
  logic mon_en = 1'b0;

  // model state: event accepted at m_acc is busy through m_end
  int m_acc = -10, m_end = -10;
  logic [W-1:0] m_idx = '0;
  int m_sb = 0, m_sm = 0, m_se = 0, m_sp = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
  endtask

  function automatic int age(logic [W-1:0] x);
    logic [W-1:0] d;
    d = x - rob_head_idx;
    return int'(d);
  endfunction

  task automatic clr(int c);
    slot[c & 15] = '{default: 0};
  endtask

  // Lay out the whole expected timeline of an event accepted in cycle c.
  task automatic schedule(int c, logic [1:0] k, logic [W-1:0] idx, logic [CW-1:0] ck, logic [31:0] pc);
    int s;
    slot[(c+1) & 15].fl = 1'b1;
    slot[(c+1) & 15].idx = idx;
    slot[(c+1) & 15].kind = k;
    if (k == 2'b10) s = c + 2;
    else begin
      for (int j = 0; j < R; j++) begin
        if (k == 2'b01) begin slot[(c+2+j) & 15].rs = 1'b1; slot[(c+2+j) & 15].ck = ck; end
        else slot[(c+2+j) & 15].ar = 1'b1;
      end
      s = c + 2 + R;
    end
    slot[s & 15].rd = 1'b1;
    slot[s & 15].pc = pc;
    m_acc = c; m_end = s; m_idx = idx;
    if (k == 2'b01) m_sb++;
    else if (k == 2'b10) m_sm++;
    else m_se++;
  endtask

  // One cycle of the reference model, using the inputs driven for this cycle.
  task automatic model_step();
    int c, best, key;
    logic bsy, have, pre;
    logic [1:0] k;
    logic [W-1:0] idx;
    logic [CW-1:0] ck;
    logic [31:0] pc;
    rec_t r;
    c = cyc;
    bsy = (c > m_acc) && (c <= m_end);
    exp_busy[c & 15] = bsy;
    have = 1'b0; pre = 1'b0; k = 0; idx = 0; ck = 0; pc = 0;
    if (exc_valid) begin
      have = 1'b1; k = 2'b11; idx = exc_rob_idx; pc = exc_pc;
    end else begin
      best = 1 << 30;
      if (memv_valid) begin
        key = age(memv_rob_idx) * (N + 2);
        if (key < best) begin best = key; have = 1'b1; k = 2'b10; idx = memv_rob_idx; pc = memv_pc; ck = 0; end
      end
      for (int i = 0; i < N; i++) if (br_valid[i]) begin
        key = age(br_rob_idx[i*W +: W]) * (N + 2) + i + 1;
        if (key < best) begin
          best = key; have = 1'b1; k = 2'b01;
          idx = br_rob_idx[i*W +: W]; pc = br_pc[i*32 +: 32]; ck = br_ckpt[i*CW +: CW];
        end
      end
    end
    if (rst) begin
      for (int j = 1; j <= 8; j++) clr(c + j);
      if (m_end > c) m_end = c;
      m_sb = 0; m_sm = 0; m_se = 0; m_sp = 0;
    end else if (!bsy) begin
      if (have) schedule(c, k, idx, ck, pc);
    end else if (have && (k == 2'b11 || age(idx) < age(m_idx))) begin
      pre = 1'b1;
      m_sp++;
      slot[c & 15].rs = 0; slot[c & 15].ck = 0; slot[c & 15].ar = 0;
      slot[c & 15].rd = 0; slot[c & 15].pc = 0;
      for (int j = 1; j <= 8; j++) clr(c + j);
      schedule(c, k, idx, ck, pc);
    end
    r = slot[c & 15];
    r.cyc = c;
    r.pre = pre;
    if (r.fl || r.rs || r.ar || r.rd || r.pre) q.push_back(r);
    clr(c);
  endtask

  // Monitor: drop overdue expectations as misses, compare on any DUT activity.
  always @(negedge clk) if (mon_en) begin
    rec_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missing_activity", 64'd0, 64'(e.cyc));
    end
    if (flush || rat_restore || rat_arch_recover || redirect_valid || preempt_pulse) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("outputs",
            64'({flush, flush_rob_idx, flush_kind, rat_restore, rat_restore_ckpt, rat_arch_recover, redirect_valid, redirect_pc, preempt_pulse}),
            64'({e.fl, e.idx, e.kind, e.rs, e.ck, e.ar, e.rd, e.pc, e.pre}));
      end else begin
        chk("unexpected_activity",
            64'({flush, flush_rob_idx, flush_kind, rat_restore, rat_restore_ckpt, rat_arch_recover, redirect_valid, redirect_pc, preempt_pulse}), 64'd0);
      end
    end
    chk("busy", 64'(busy), 64'(exp_busy[cyc & 15]));
  end

  task automatic nc();
    @(posedge clk);
    #1;
    rst = 1'b0; exc_valid = 1'b0; memv_valid = 1'b0; br_valid = '0;
  endtask

  task automatic idle(int n);
    repeat (n) begin nc(); model_step(); end
  endtask

  task automatic set_br(int p, int idx, int ck, logic [31:0] pc);
    br_valid[p] = 1'b1;
    br_rob_idx[p*W +: W] = W'(idx);
    br_ckpt[p*CW +: CW] = CW'(ck);
    br_pc[p*32 +: 32] = pc;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin clr(i); exp_busy[i] = 1'b0; end
    @(posedge clk); #1;
    model_step();
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        64'({flush, flush_rob_idx, flush_kind, rat_restore, rat_restore_ckpt, rat_arch_recover, redirect_valid, redirect_pc, busy, preempt_pulse}), 64'd0);

    // single branch
    nc(); rob_head_idx = 7'd5; set_br(0, 9, 3, 32'h0040_0100); model_step(); idle(8);
    // wrap-around age pick: port1 idx 125 is older than port0 idx 2
    nc(); rob_head_idx = 7'd120; set_br(0, 2, 1, 32'h1000); set_br(1, 125, 2, 32'h2000); model_step(); idle(8);
    // memv preempts a branch in RESTORE
    nc(); rob_head_idx = 7'd10; set_br(0, 20, 5, 32'h3000); model_step();
    idle(1);
    nc(); memv_valid = 1'b1; memv_rob_idx = 7'd15; memv_pc = 32'h0000_0800; model_step(); idle(6);
    // younger branch during REDIRECT is dropped
    nc(); set_br(0, 20, 4, 32'h4000); model_step(); idle(R + 1);
    nc(); set_br(1, 30, 6, 32'h5000); model_step(); idle(6);
    // exception during REDIRECT preempts
    nc(); set_br(0, 20, 4, 32'h4100); model_step(); idle(R + 1);
    nc(); exc_valid = 1'b1; exc_rob_idx = 7'd40; exc_pc = 32'hDEAD_0000; model_step(); idle(8);
    // plain exception: arch recover for R cycles
    nc(); rob_head_idx = 7'd0; exc_valid = 1'b1; exc_rob_idx = 7'd7; exc_pc = 32'h0000_0180; model_step(); idle(8);
    // reset while in FLUSH
    nc(); set_br(1, 3, 2, 32'h6000); model_step();
    nc(); rst = 1'b1; model_step(); idle(5);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      nc();
      rob_head_idx = rob_head_idx + W'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        exc_valid = 1'b1; exc_rob_idx = rob_head_idx + W'($urandom_range(0, 40)); exc_pc = $urandom;
      end
      if ($urandom_range(0, 5) == 0) begin
        memv_valid = 1'b1; memv_rob_idx = rob_head_idx + W'($urandom_range(0, 40)); memv_pc = $urandom;
      end
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 4) == 0)
          set_br(p, int'(rob_head_idx) + $urandom_range(0, 40), $urandom_range(0, 7), $urandom);
      if (memv_valid && br_valid[0] && $urandom_range(0, 2) == 0) br_rob_idx[0 +: W] = memv_rob_idx;
      model_step();
    end
    idle(10);
    chk("drain", 64'(q.size()), 64'd0);
`ifdef RECOVERY_ARBITER_STATS_EN
    chk("stat_branch", 64'(stat_branch), 64'(m_sb));
    chk("stat_memory", 64'(stat_memory), 64'(m_sm));
    chk("stat_exception", 64'(stat_exception), 64'(m_se));
    chk("stat_preempt", 64'(stat_preempt), 64'(m_sp));
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
